// File: rtl/half_subtractor.sv
// Bit-wise half subtractor: combinational diff/borrow plus a valid-qualified registered copy.
// Optional saturating borrow-event counter is built only when HS_BORROW_COUNT_EN is defined.
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] diff,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borrow_q,
  output logic             out_valid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] borrow_cnt
);

  logic [WIDTH-1:0] r_diff_q;
  logic [WIDTH-1:0] r_borrow_q;
  logic             r_out_valid;

  // Lanes are independent; no borrow ripples between them.
  assign diff   = a ^ b;
  assign borrow = ~a & b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff_q    <= {WIDTH{1'b0}};
      r_borrow_q  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_diff_q    <= diff;
      r_borrow_q  <= borrow;
      r_out_valid <= 1'b1;
    end else begin
      r_diff_q    <= r_diff_q;
      r_borrow_q  <= r_borrow_q;
      r_out_valid <= 1'b0;
    end
  end

  assign diff_q    = r_diff_q;
  assign borrow_q  = r_borrow_q;
  assign out_valid = r_out_valid;

`ifdef HS_BORROW_COUNT_EN
  logic [CNT_W-1:0] r_borrow_cnt;
  logic             w_any_borrow;
  logic             w_cnt_full;

  assign w_any_borrow = |borrow;
  assign w_cnt_full   = &r_borrow_cnt;

  // Clear wins over an increment in the same cycle; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_borrow_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_borrow_cnt <= {CNT_W{1'b0}};
    end else if (in_valid && w_any_borrow && !w_cnt_full) begin
      r_borrow_cnt <= r_borrow_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_borrow_cnt <= r_borrow_cnt;
    end
  end

  assign borrow_cnt = r_borrow_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign borrow_cnt       = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Directed bench for half_subtractor: truth-table vectors, registered latency, reset and counter.
module tb_half_subtractor;

`ifdef HS_BORROW_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, cnt_clr;
  logic [0:0] a1, b1, bor1, dif1, dq1, bq1, dqs, bqs, bors, difs;
  logic ov1, ovs, ov4;
  logic [15:0] cnt1;
  logic [1:0]  cnts;
  logic [3:0]  a4, b4, bor4, dif4, dq4, bq4;
  logic [15:0] cnt4;

  int n_cmp = 0;
  int n_err = 0;

  logic       exp_dq, exp_bq, exp_ov;
  int         exp_cnt, exp_cnts;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] bor;
    logic [3:0] dif;
  } vec_t;
  vec_t v1[4];
  vec_t v4[5];

  half_subtractor #(.WIDTH(1), .CNT_W(16)) dut1 (
    .a(a1), .b(b1), .borrow(bor1), .diff(dif1), .clk(clk), .rst(rst),
    .in_valid(in_valid), .diff_q(dq1), .borrow_q(bq1), .out_valid(ov1),
    .cnt_clr(cnt_clr), .borrow_cnt(cnt1));

  half_subtractor #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .a(a1), .b(b1), .borrow(bors), .diff(difs), .clk(clk), .rst(rst),
    .in_valid(in_valid), .diff_q(dqs), .borrow_q(bqs), .out_valid(ovs),
    .cnt_clr(cnt_clr), .borrow_cnt(cnts));

  half_subtractor #(.WIDTH(4), .CNT_W(16)) dut4 (
    .a(a4), .b(b4), .borrow(bor4), .diff(dif4), .clk(clk), .rst(rst),
    .in_valid(in_valid), .diff_q(dq4), .borrow_q(bq4), .out_valid(ov4),
    .cnt_clr(cnt_clr), .borrow_cnt(cnt4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clocked transaction on the shared WIDTH=1 inputs, checked against a small reference model.
  task automatic step(input logic ta, input logic tb, input logic tv, input logic tclr);
    @(negedge clk);
    a1 = ta; b1 = tb; in_valid = tv; cnt_clr = tclr;
    @(posedge clk);
    exp_ov = tv;
    if (tv) begin
      exp_dq = ta ^ tb;
      exp_bq = (ta == 1'b0) && (tb == 1'b1);
    end
    if (CNT_EN) begin
      if (tclr) begin
        exp_cnt = 0; exp_cnts = 0;
      end else if (tv && (ta == 1'b0) && (tb == 1'b1)) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnts < 3) exp_cnts++;
      end
    end
    #1;
    chk("diff_q", {31'd0, dq1}, {31'd0, exp_dq});
    chk("borrow_q", {31'd0, bq1}, {31'd0, exp_bq});
    chk("out_valid", {31'd0, ov1}, {31'd0, exp_ov});
    chk("borrow_cnt", {16'd0, cnt1}, exp_cnt);
    chk("borrow_cnt_sat", {30'd0, cnts}, exp_cnts);
  endtask

  initial begin
    v1[0] = '{4'd0, 4'd0, 4'd0, 4'd0};
    v1[1] = '{4'd0, 4'd1, 4'd1, 4'd1};
    v1[2] = '{4'd1, 4'd0, 4'd0, 4'd1};
    v1[3] = '{4'd1, 4'd1, 4'd0, 4'd0};
    v4[0] = '{4'b0101, 4'b0011, 4'b0010, 4'b0110};
    v4[1] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    v4[2] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    v4[3] = '{4'b1100, 4'b1010, 4'b0010, 4'b0110};
    v4[4] = '{4'b1001, 4'b1001, 4'b0000, 4'b0000};

    rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'b0000; b4 = 4'b0000;

    // Combinational sweep at 5 ns steps, independent of the clocked state.
    for (int i = 0; i < 4; i++) begin
      a1 = v1[i].a[0:0]; b1 = v1[i].b[0:0];
      #4;
      chk($sformatf("comb1_borrow[%0d]", i), {31'd0, bor1}, {28'd0, v1[i].bor});
      chk($sformatf("comb1_diff[%0d]", i), {31'd0, dif1}, {28'd0, v1[i].dif});
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      a4 = v4[i].a; b4 = v4[i].b;
      #1;
      chk($sformatf("comb4_borrow[%0d]", i), {28'd0, bor4}, {28'd0, v4[i].bor});
      chk($sformatf("comb4_diff[%0d]", i), {28'd0, dif4}, {28'd0, v4[i].dif});
    end
    a4 = 4'b0101; b4 = 4'b0011;

    // Asynchronous reset with a borrowing sample presented: outputs clear without an edge.
    @(negedge clk);
    in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_diff_q", {31'd0, dq1}, 32'd0);
    chk("rst_borrow_q", {31'd0, bq1}, 32'd0);
    chk("rst_out_valid", {31'd0, ov1}, 32'd0);
    chk("rst_borrow_cnt", {16'd0, cnt1}, 32'd0);
    chk("rst_comb_borrow", {31'd0, bor1}, 32'd1);
    chk("rst_comb_diff", {31'd0, dif1}, 32'd1);
    @(posedge clk); #1;
    chk("rst_hold_out_valid", {31'd0, ov1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_dq = 1'b0; exp_bq = 1'b0; exp_ov = 1'b0; exp_cnt = 0; exp_cnts = 0;

    // Latency, hold on idle, and the WIDTH=4 registered copy.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("w4_diff_q", {28'd0, dq4}, {28'd0, 4'b0110});
    chk("w4_borrow_q", {28'd0, bq4}, {28'd0, 4'b0010});
    chk("w4_out_valid", {31'd0, ov4}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Counter: 3 borrowing + 2 non-borrowing samples, then clear racing a borrow.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("cnt_three", {16'd0, cnt1}, CNT_EN ? 32'd3 : 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("cnt_clr_priority", {16'd0, cnt1}, 32'd0);

    // Saturation on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("cnt_sat", {30'd0, cnts}, CNT_EN ? 32'd3 : 32'd0);
    chk("cnt_wide", {16'd0, cnt1}, CNT_EN ? 32'd5 : 32'd0);

    // Mid-stream reset discards the in-flight sample; next valid edge is normal.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; in_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_borrow_q", {31'd0, bq1}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt1}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {31'd0, ov1}, 32'd0);
    chk("mid_rst_diff_q", {31'd0, dq1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_dq = 1'b0; exp_bq = 1'b0; exp_ov = 1'b0; exp_cnt = 0; exp_cnts = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
